// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared encodings for the pipelined instruction/data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam logic [1:0] MEMOP_NONE  = 2'b00;
  localparam logic [1:0] MEMOP_LOADS = 2'b01;
  localparam logic [1:0] MEMOP_STORE = 2'b10;
  localparam logic [1:0] MEMOP_LOADU = 2'b11;

  localparam logic [1:0] MEMSIZE_BYTE    = 2'b00;
  localparam logic [1:0] MEMSIZE_HALF    = 2'b01;
  localparam logic [1:0] MEMSIZE_WORD    = 2'b10;
  localparam logic [1:0] MEMSIZE_ILLEGAL = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bState_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Store byte-lane enables/replication and load lane extract/extend.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_stSize,
  input  logic [1:0]  i_stOffset,
  input  logic [31:0] i_stData,
  output logic [3:0]  o_wen,
  output logic [31:0] o_wdata,
  input  logic [1:0]  i_ldSize,
  input  logic [1:0]  i_ldOffset,
  input  logic        i_ldSigned,
  input  logic [31:0] i_ldWord,
  output logic [31:0] o_ldData
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_wen   = 4'b0000;
    o_wdata = i_stData;
    case (i_stSize)
      MEMSIZE_BYTE: begin
        o_wen   = 4'b0001 << i_stOffset;
        o_wdata = {4{i_stData[7:0]}};
      end
      MEMSIZE_HALF: begin
        o_wen   = i_stOffset[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_stData[15:0]}};
      end
      MEMSIZE_WORD: o_wen = 4'b1111;
      default:      o_wen = 4'b0000;
    endcase
  end

  always_comb begin
    w_byte   = i_ldWord[{i_ldOffset, 3'b000} +: 8];
    w_half   = i_ldWord[{i_ldOffset[1], 4'b0000} +: 16];
    o_ldData = i_ldWord;
    case (i_ldSize)
      MEMSIZE_BYTE: o_ldData = {{24{i_ldSigned & w_byte[7]}}, w_byte};
      MEMSIZE_HALF: o_ldData = {{16{i_ldSigned & w_half[15]}}, w_half};
      default:      o_ldData = i_ldWord;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_subsystem_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : mem_subsystem_pipelined
// Description : Dual-port word RAM with pipelined fetch port, handshaked
//               load/store port and a small MMIO register window.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_subsystem_pipelined
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 1024,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] MMIO_BASE    = 32'hF000_0000,
  parameter int          NUM_MMIO     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enA,
  input  logic [31:0]           instrAddr,
  input  logic [31:0]           alu,
  input  logic [31:0]           din,
  input  logic [1:0]            memOp,
  input  logic [1:0]            memSize,
  output logic [31:0]           doutA,
  output logic [31:0]           doutB,
  output logic [31:0]           addrAOut,
  output logic [31:0]           addrBOut,
  output logic                  readValidA,
  output logic                  readValidB,
  output logic                  ready,
  output logic                  busErr,
  output logic [32*NUM_MMIO-1:0] mmioOut
);

  localparam int          c_AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] c_RAM_END  = 33'(4 * DEPTH_WORDS);
  localparam logic [32:0] c_MMIO_END = {1'b0, MMIO_BASE} + 33'(4 * NUM_MMIO);
  localparam logic [1:0]  c_ACC_LAST = 2'(READ_LATENCY - 2);

  logic [31:0] r_mem  [DEPTH_WORDS];
  logic [31:0] r_mmio [NUM_MMIO];

  // ---------------- Port A: free-running fetch pipeline ----------------
  logic [READ_LATENCY-1:0] r_aValid;
  logic [31:0]             r_aData [READ_LATENCY];
  logic [31:0]             r_aAddr [READ_LATENCY];
  logic                    w_aInRam;

  assign w_aInRam = {1'b0, instrAddr} < c_RAM_END;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_aValid[i] <= 1'b0;
        r_aData[i]  <= 32'h0;
        r_aAddr[i]  <= 32'h0;
      end
    end else begin
      r_aValid[0] <= enA;
      r_aAddr[0]  <= instrAddr;
      r_aData[0]  <= w_aInRam ? r_mem[instrAddr[c_AW+1:2]] : NOP_INSTR;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_aValid[i] <= r_aValid[i-1];
        r_aData[i]  <= r_aData[i-1];
        r_aAddr[i]  <= r_aAddr[i-1];
      end
    end
  end

  assign readValidA = r_aValid[READ_LATENCY-1];
  assign doutA      = r_aData[READ_LATENCY-1];
  assign addrAOut   = r_aAddr[READ_LATENCY-1];

  // ---------------- Port B: decode and accept ----------------
  bState_t     r_state, w_next;
  logic [1:0]  r_cnt, r_size;
  logic [31:0] r_addr, r_ldWord, w_mmioRd, w_wdata, w_ldData;
  logic        r_signed, r_isLoad, r_busErr;
  logic        w_bInRam, w_bInMmio, w_bad, w_req, w_accept, w_err, w_store;
  logic [3:0]  w_mmioIdx, w_wen;
  logic [c_AW-1:0] w_bIdx;

  assign w_bInRam  = {1'b0, alu} < c_RAM_END;
  assign w_bInMmio = ({1'b0, alu} >= {1'b0, MMIO_BASE}) && ({1'b0, alu} < c_MMIO_END);
  assign w_bad     = (memSize == MEMSIZE_ILLEGAL)
                   || ((memSize == MEMSIZE_HALF) && alu[0])
                   || ((memSize == MEMSIZE_WORD) && (alu[1:0] != 2'b00))
                   || !(w_bInRam || w_bInMmio);
  assign w_req     = (r_state != ST_ACCESS) && (memOp != MEMOP_NONE);
  assign w_accept  = w_req && !w_bad;
  assign w_err     = w_req && w_bad;
  assign w_store   = w_accept && (memOp == MEMOP_STORE);
  assign w_bIdx    = alu[c_AW+1:2];
  assign w_mmioIdx = 4'((alu - MMIO_BASE) >> 2);

  always_comb begin
    w_mmioRd = 32'h0;
    for (int i = 0; i < NUM_MMIO; i++)
      if (w_mmioIdx == 4'(i)) w_mmioRd = r_mmio[i];
  end

  mem_lane_align u_align (
    .i_stSize  (memSize),
    .i_stOffset(alu[1:0]),
    .i_stData  (din),
    .o_wen     (w_wen),
    .o_wdata   (w_wdata),
    .i_ldSize  (r_size),
    .i_ldOffset(r_addr[1:0]),
    .i_ldSigned(r_signed),
    .i_ldWord  (r_ldWord),
    .o_ldData  (w_ldData)
  );

  // RAM keeps its contents through reset, so it has no reset branch.
  always_ff @(posedge clk) begin
    if (w_store && w_bInRam)
      for (int b = 0; b < 4; b++)
        if (w_wen[b]) r_mem[w_bIdx][8*b +: 8] <= w_wdata[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_MMIO; i++) r_mmio[i] <= 32'h0;
    end else if (w_store && w_bInMmio) begin
      for (int i = 0; i < NUM_MMIO; i++)
        for (int b = 0; b < 4; b++)
          if ((w_mmioIdx == 4'(i)) && w_wen[b]) r_mmio[i][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  for (genvar g = 0; g < NUM_MMIO; g++) begin : g_mmioOut
    assign mmioOut[32*g +: 32] = r_mmio[g];
  end

  // ---------------- Port B: handshake FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 2'd0;
      r_addr   <= 32'h0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_isLoad <= 1'b0;
      r_ldWord <= 32'h0;
      r_busErr <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_busErr <= w_err;
      if (r_state == ST_ACCESS) r_cnt <= r_cnt + 2'd1;
      if (w_accept) begin
        r_cnt    <= 2'd0;
        r_addr   <= alu;
        r_size   <= memSize;
        r_signed <= (memOp == MEMOP_LOADS);
        r_isLoad <= (memOp != MEMOP_STORE);
        r_ldWord <= w_bInMmio ? w_mmioRd : r_mem[w_bIdx];
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    ready      = (r_state != ST_ACCESS);
    readValidB = (r_state == ST_RESP);
    addrBOut   = (r_state == ST_RESP) ? r_addr : 32'h0;
    doutB      = ((r_state == ST_RESP) && r_isLoad) ? w_ldData : 32'h0;
    busErr     = r_busErr;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_accept) w_next = (READ_LATENCY == 1) ? ST_RESP : ST_ACCESS;
        else          w_next = ST_IDLE;
      end
      ST_ACCESS: if (r_cnt == c_ACC_LAST) w_next = ST_RESP;
      default:   w_next = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_subsystem_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_subsystem_pipelined
// Description : Directed bench for mem_subsystem_pipelined at latencies 2 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_subsystem_pipelined;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enA = 1'b0;
  logic [31:0] instrAddr = 32'h0, alu = 32'h0, din = 32'h0;
  logic [1:0]  memOp = MEMOP_NONE, memSize = MEMSIZE_WORD;

  logic [31:0]  doutA, doutB, addrAOut, addrBOut;
  logic         readValidA, readValidB, ready, busErr;
  logic [127:0] mmioOut;
  logic [31:0]  doutA3, doutB3, addrAOut3, addrBOut3;
  logic         readValidA3, readValidB3, ready3, busErr3;
  logic [127:0] mmioOut3;

  int nCmp = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  mem_subsystem_pipelined #(.DEPTH_WORDS(1024), .READ_LATENCY(2),
                            .MMIO_BASE(32'hF000_0000), .NUM_MMIO(4)) dut (
    .clk(clk), .reset(reset), .enA(enA), .instrAddr(instrAddr), .alu(alu),
    .din(din), .memOp(memOp), .memSize(memSize), .doutA(doutA), .doutB(doutB),
    .addrAOut(addrAOut), .addrBOut(addrBOut), .readValidA(readValidA),
    .readValidB(readValidB), .ready(ready), .busErr(busErr), .mmioOut(mmioOut));

  mem_subsystem_pipelined #(.DEPTH_WORDS(1024), .READ_LATENCY(3),
                            .MMIO_BASE(32'hF000_0000), .NUM_MMIO(4)) dut3 (
    .clk(clk), .reset(reset), .enA(enA), .instrAddr(instrAddr), .alu(alu),
    .din(din), .memOp(memOp), .memSize(memSize), .doutA(doutA3), .doutB(doutB3),
    .addrAOut(addrAOut3), .addrBOut(addrBOut3), .readValidA(readValidA3),
    .readValidB(readValidB3), .ready(ready3), .busErr(busErr3), .mmioOut(mmioOut3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one port-B request for a single accept edge, then withdraws it.
  task automatic bIssue(input logic [1:0] op, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
    memOp = op; memSize = sz; alu = a; din = d;
    tick();
    memOp = MEMOP_NONE;
  endtask

  // Full transaction for the latency-2 instance; leaves it IDLE, latency-3 in RESP.
  task automatic bStore(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bIssue(MEMOP_STORE, sz, a, d);
    tick();
    tick();
  endtask

  task automatic bLoad(input string tag, input logic [1:0] op, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] exp);
    bIssue(op, sz, a, 32'h0);
    tick();
    chk({tag, "_valid"}, {31'b0, readValidB}, 32'd1);
    chk(tag, doutB, exp);
    tick();
    chk({tag, "_lat3"}, doutB3, exp);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ready",  {31'b0, ready},      32'd1);
    chk("rst_rvA",    {31'b0, readValidA}, 32'd0);
    chk("rst_rvB",    {31'b0, readValidB}, 32'd0);
    chk("rst_busErr", {31'b0, busErr},     32'd0);
    for (int i = 0; i < 4; i++) chk("rst_mmio", mmioOut[32*i +: 32], 32'h0);
    reset = 1'b0;

    // Seed an instruction word, checking the store handshake timing.
    bIssue(MEMOP_STORE, MEMSIZE_WORD, 32'h10, 32'h0050_0093);
    chk("st_busy_ready", {31'b0, ready}, 32'd0);
    tick();
    chk("st_done_valid", {31'b0, readValidB}, 32'd1);
    chk("st_done_addr",  addrBOut, 32'h10);
    chk("st_done_ready", {31'b0, ready}, 32'd1);
    tick();
    chk("st_after_valid", {31'b0, readValidB}, 32'd0);

    // Fetch: latency 2 on dut, 3 on dut3.
    enA = 1'b1; instrAddr = 32'h10;
    tick();
    enA = 1'b0;
    chk("fetch_early", {31'b0, readValidA}, 32'd0);
    tick();
    chk("fetch_valid", {31'b0, readValidA}, 32'd1);
    chk("fetch_data",  doutA, 32'h0050_0093);
    chk("fetch_addr",  addrAOut, 32'h10);
    chk("fetch3_early", {31'b0, readValidA3}, 32'd0);
    tick();
    chk("fetch_pulse", {31'b0, readValidA}, 32'd0);
    chk("fetch3_valid", {31'b0, readValidA3}, 32'd1);
    chk("fetch3_data",  doutA3, 32'h0050_0093);

    // Fetch beyond RAM yields nop with no bus error.
    enA = 1'b1; instrAddr = 32'h0000_4000;
    tick();
    enA = 1'b0;
    tick();
    chk("nop_valid", {31'b0, readValidA}, 32'd1);
    chk("nop_data",  doutA, NOP_INSTR);
    chk("nop_busErr", {31'b0, busErr}, 32'd0);
    tick();

    // Byte-lane stores and sign/zero-extended loads.
    bStore(MEMSIZE_WORD, 32'h20, 32'h1122_3344);
    bStore(MEMSIZE_BYTE, 32'h21, 32'h0000_0080);
    bLoad("ld_sb",  MEMOP_LOADS, MEMSIZE_BYTE, 32'h21, 32'hFFFF_FF80);
    bLoad("ld_ub",  MEMOP_LOADU, MEMSIZE_BYTE, 32'h21, 32'h0000_0080);
    bLoad("ld_sh",  MEMOP_LOADS, MEMSIZE_HALF, 32'h20, 32'hFFFF_8044);
    bLoad("ld_uh",  MEMOP_LOADU, MEMSIZE_HALF, 32'h22, 32'h0000_1122);
    bLoad("ld_w",   MEMOP_LOADS, MEMSIZE_WORD, 32'h20, 32'h1122_8044);

    // Misaligned half store: one-cycle busErr, no write, no completion.
    bIssue(MEMOP_STORE, MEMSIZE_HALF, 32'h23, 32'h0000_FFFF);
    chk("mis_busErr", {31'b0, busErr}, 32'd1);
    chk("mis_ready",  {31'b0, ready},  32'd1);
    chk("mis_busErr3", {31'b0, busErr3}, 32'd1);
    tick();
    chk("mis_pulse", {31'b0, busErr}, 32'd0);
    chk("mis_noValid", {31'b0, readValidB}, 32'd0);
    bLoad("mis_unchanged", MEMOP_LOADU, MEMSIZE_WORD, 32'h20, 32'h1122_8044);

    bIssue(MEMOP_LOADU, MEMSIZE_ILLEGAL, 32'h20, 32'h0);
    chk("illegal_busErr", {31'b0, busErr}, 32'd1);
    tick();
    bIssue(MEMOP_LOADU, MEMSIZE_WORD, 32'h0000_8000, 32'h0);
    chk("unmapped_busErr", {31'b0, busErr}, 32'd1);
    tick();
    chk("unmapped_noValid", {31'b0, readValidB}, 32'd0);

    // MMIO window.
    bIssue(MEMOP_STORE, MEMSIZE_WORD, 32'hF000_0004, 32'hDEAD_BEEF);
    chk("mmio1_word", mmioOut[63:32], 32'hDEAD_BEEF);
    tick();
    tick();
    bLoad("mmio_ldw", MEMOP_LOADU, MEMSIZE_WORD, 32'hF000_0004, 32'hDEAD_BEEF);
    bStore(MEMSIZE_BYTE, 32'hF000_0002, 32'h0000_005A);
    chk("mmio0_byte", mmioOut[31:0], 32'h005A_0000);
    bLoad("mmio_ldsb", MEMOP_LOADS, MEMSIZE_BYTE, 32'hF000_0007, 32'hFFFF_FFDE);

    // Same-word fetch and store in one cycle: fetch sees the old word.
    enA = 1'b1; instrAddr = 32'h10;
    bIssue(MEMOP_STORE, MEMSIZE_WORD, 32'h10, 32'hCAFE_F00D);
    enA = 1'b0;
    tick();
    chk("rf_old", doutA, 32'h0050_0093);
    tick();
    chk("rf_old3", doutA3, 32'h0050_0093);
    enA = 1'b1;
    tick();
    enA = 1'b0;
    tick();
    chk("rf_new", doutA, 32'hCAFE_F00D);
    tick();
    bLoad("rf_ld", MEMOP_LOADU, MEMSIZE_WORD, 32'h10, 32'hCAFE_F00D);

    // Reset while the latency-3 instance is in ACCESS drops the store's response.
    bIssue(MEMOP_STORE, MEMSIZE_WORD, 32'h30, 32'h1234_5678);
    chk("rst_acc_busy3", {31'b0, ready3}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_acc_ready3", {31'b0, ready3}, 32'd1);
    chk("rst_acc_ready",  {31'b0, ready},  32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("rst_acc_noValid3", {31'b0, readValidB3}, 32'd0);
      chk("rst_acc_noValid",  {31'b0, readValidB},  32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
`default_nettype wire
